// File: rtl/xbar_input_queue.sv
// Elastic FIFO in front of one crossbar input port; strict order, no drops.
// Define XBAR_INPUT_QUEUE_BYPASS_EN for zero-latency pass-through when empty.
module xbar_input_queue #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BIT_WIDTH-1:0]         recv_msg,
    input  logic                         recv_val,
    output logic                         recv_rdy,
    output logic [BIT_WIDTH-1:0]         send_msg,
    output logic                         send_val,
    input  logic                         send_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 bypass;
    logic                 enq;
    logic                 deq;

    assign empty = (count == '0);
    assign full  = (count == FULL);

`ifdef XBAR_INPUT_QUEUE_BYPASS_EN
    assign bypass = empty && recv_val && !reset;
`else
    assign bypass = 1'b0;
`endif

    // Ready depends only on state, never on send_rdy.
    assign recv_rdy = !full && !reset;
    assign send_val = (!empty || bypass) && !reset;

    always_comb begin
        send_msg = '0;
        if (bypass)
            send_msg = recv_msg;
        else if (send_val)
            send_msg = mem[rd_ptr];
    end

    // A bypassed message consumed this cycle never touches storage.
    assign enq = recv_val && recv_rdy && !(bypass && send_rdy);
    assign deq = !empty && send_rdy && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)
                count <= count + 1'b1;
            else if (deq && !enq)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= recv_msg;
    end

endmodule

// File: tb/tb_xbar_input_queue.sv
// Directed self-checking bench for xbar_input_queue (DEPTH=4, 32-bit).
// Bypass-only checks are compiled when XBAR_INPUT_QUEUE_BYPASS_EN is defined.
module tb_xbar_input_queue;

    localparam int BW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] recv_msg;
    logic          recv_val;
    logic          recv_rdy;
    logic [BW-1:0] send_msg;
    logic          send_val;
    logic          send_rdy;
    logic [2:0]    count;

    int n_tests = 0;
    int n_fail  = 0;

    xbar_input_queue #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        send_rdy = 1'b0;
        for (int i = 0; i < n; i++) begin
            recv_val = 1'b1;
            recv_msg = base + 32'(i);
            #1;
            chk("fill_rdy", 32'(recv_rdy), 32'd1);
            step();
        end
        recv_val = 1'b0;
        #1;
    endtask

    logic [31:0] q[$];
    int          got_n;
    logic        sv_exp;
    logic [31:0] exp_v;

    initial begin
        reset = 1'b1;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        #1;
        chk("rst_recv_rdy", 32'(recv_rdy), 32'd0);
        chk("rst_send_val", 32'(send_val), 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_send_val", 32'(send_val), 32'd0);
        chk("idle_send_msg", send_msg, 32'd0);
        chk("idle_recv_rdy", 32'(recv_rdy), 32'd1);
        send_rdy = 1'b1;
        step();
        chk("idle_no_xfer", 32'(count), 32'd0);

        // Fill to full, reject a fifth message, then drain in order.
        fill(32'hA0, 4);
        chk("full_count", 32'(count), 32'd4);
        chk("full_recv_rdy", 32'(recv_rdy), 32'd0);
        recv_val = 1'b1;
        recv_msg = 32'hA4;
        step();
        recv_val = 1'b0;
        #1;
        chk("full_reject", 32'(count), 32'd4);
        send_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_val", 32'(send_val), 32'd1);
            chk("drain_msg", send_msg, 32'hA0 + 32'(i));
            step();
        end
        chk("drain_empty_val", 32'(send_val), 32'd0);
        chk("drain_empty_msg", send_msg, 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // Streaming 1..10 with a scoreboard queue.
        q.delete();
        got_n = 0;
        send_rdy = 1'b1;
        for (int c = 0; c < 30 && got_n < 10; c++) begin
            recv_val = (c < 10);
            recv_msg = 32'(c + 1);
            #1;
`ifdef XBAR_INPUT_QUEUE_BYPASS_EN
            sv_exp = (q.size() > 0) || recv_val;
`else
            sv_exp = (q.size() > 0);
            if (c >= 1 && c < 10)
                chk("stream_count", 32'(count), 32'd1);
`endif
            chk("stream_val", 32'(send_val), 32'(sv_exp));
            if (recv_val && q.size() < DEPTH)
                q.push_back(recv_msg);
            if (sv_exp && q.size() > 0) begin
                exp_v = q.pop_front();
                chk("stream_msg", send_msg, exp_v);
                got_n++;
            end
            step();
        end
        recv_val = 1'b0;
        chk("stream_total", 32'(got_n), 32'd10);

        // Simultaneous enqueue and dequeue at full: only the dequeue happens.
        fill(32'hB0, 4);
        chk("sim_full", 32'(count), 32'd4);
        recv_val = 1'b1;
        recv_msg = 32'hBB;
        send_rdy = 1'b1;
        #1;
        chk("sim_head", send_msg, 32'hB0);
        step();
        chk("sim_count", 32'(count), 32'd3);
        chk("sim_rdy_back", 32'(recv_rdy), 32'd1);
        send_rdy = 1'b0;
        step();
        recv_val = 1'b0;
        #1;
        chk("sim_accept", 32'(count), 32'd4);
        send_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_v = (i == 3) ? 32'hBB : 32'hB1 + 32'(i);
            chk("sim_order", send_msg, exp_v);
            step();
        end
        chk("sim_drained", 32'(count), 32'd0);

        // Reset mid-stream flushes stored entries and wins over enqueue.
        fill(32'hC0, 3);
        chk("mid_count3", 32'(count), 32'd3);
        recv_val = 1'b1;
        recv_msg = 32'hC3;
        reset = 1'b1;
        #1;
        chk("mid_rst_rdy", 32'(recv_rdy), 32'd0);
        chk("mid_rst_val", 32'(send_val), 32'd0);
        chk("mid_rst_msg", send_msg, 32'd0);
        step();
        reset = 1'b0;
        recv_val = 1'b0;
        send_rdy = 1'b1;
        #1;
        chk("mid_count0", 32'(count), 32'd0);
        chk("mid_val0", 32'(send_val), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_stale", send_msg, 32'd0);
        end
        send_rdy = 1'b0;
        fill(32'hD0, 1);
        chk("mid_new_head", send_msg, 32'hD0);
        send_rdy = 1'b1;
        step();
        chk("mid_after", 32'(count), 32'd0);

`ifdef XBAR_INPUT_QUEUE_BYPASS_EN
        recv_val = 1'b1;
        recv_msg = 32'h55;
        send_rdy = 1'b1;
        #1;
        chk("byp_val", 32'(send_val), 32'd1);
        chk("byp_msg", send_msg, 32'h55);
        step();
        chk("byp_count", 32'(count), 32'd0);
        send_rdy = 1'b0;
        #1;
        chk("byp_hold_msg", send_msg, 32'h55);
        step();
        recv_val = 1'b0;
        #1;
        chk("byp_enq_count", 32'(count), 32'd1);
        chk("byp_head", send_msg, 32'h55);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
